sram_req_arbiter: RTL and testbench
===================================

SRAM_REQ_ARBITER -- requirements
Module: sram_req_arbiter

Interface
REQ-001 SHALL take parameter NUM_CH, default 2, number of upstream request channels (index 0 = data port, 1 = inst port).
REQ-002 SHALL take parameter ADDR_W, default 32, address width.
REQ-003 SHALL take parameter DATA_W, default 32, data width.
REQ-004 SHALL take parameter DEPTH, default 4, maximum outstanding accepted-but-unanswered requests (power of 2, >=2).
REQ-005 SHALL have one clock and synchronous, active-low reset: clk  in  1  clock, all state on rising edge.
REQ-006 SHALL have resetn  in  1  synchronous active-low reset.
REQ-007 SHALL have ch_req  in  NUM_CH  per-channel request valid.
REQ-008 SHALL have ch_wr  in  NUM_CH  per-channel write flag.
REQ-009 SHALL have ch_size  in  2*NUM_CH  per-channel size (0=byte, 1=half, 2=word).
REQ-010 SHALL have ch_addr  in  ADDR_W*NUM_CH and ch_wdata  in  DATA_W*NUM_CH, channel i in slice i.
REQ-011 SHALL have ch_addr_ok  out  NUM_CH  per-channel request accepted.
REQ-012 SHALL have ch_data_ok  out  NUM_CH  per-channel response valid; ch_rdata  out  DATA_W  response data shared by all channels.
REQ-013 SHALL have m_req  out  1, m_wr  out  1, m_size  out  2, m_addr  out  ADDR_W, m_wdata  out  DATA_W  downstream SRAM-like request.
REQ-014 SHALL have m_addr_ok  in  1, m_data_ok  in  1, m_rdata  in  DATA_W  downstream acceptance and in-order response.

Function
REQ-015 SHALL select one channel per cycle, combinationally; m_wr/m_size/m_addr/m_wdata driven from the selected channel; m_req = ch_req[sel] && !full && !lock_void.
REQ-016 SHALL accept when m_req && m_addr_ok, asserting ch_addr_ok[sel] only, same cycle; all other ch_addr_ok low.
REQ-017 SHALL lock grant to sel while m_req high and m_addr_ok low; lock released on acceptance; locked channel not re-arbitrated even if a higher-priority channel requests.
REQ-018 SHALL, if the locked channel drops ch_req (illegal), release lock next cycle and issue nothing that cycle (lock_void).
REQ-019 SHALL on acceptance push sel index into an ID FIFO of DEPTH entries; count width clog2(DEPTH+1); pointers wrap modulo DEPTH.
REQ-020 SHALL on m_data_ok with FIFO non-empty pop head and assert ch_data_ok[head] same cycle; ch_rdata = m_rdata; zero-cycle latency both directions.
REQ-021 SHALL ignore m_data_ok when FIFO empty: no ch_data_ok, count stays 0.
REQ-022 SHALL hold m_req low when count == DEPTH (full); pop in the same cycle does not unblock until the next cycle.
REQ-023 SHALL allow push and pop in the same cycle when not full; count unchanged.
REQ-024 SHALL keep responses strictly in acceptance order across channels.

Reset
REQ-025 SHALL, while resetn low at a clk edge, clear count, read/write pointers, lock, round-robin pointer to 0.
REQ-026 SHALL drive m_req, all ch_addr_ok and ch_data_ok low whenever resetn is low, regardless of inputs; outstanding IDs are discarded mid-operation.

Configuration
REQ-027 SHALL use macro ARB_ROUND_ROBIN_EN: defined -> round-robin, highest priority to (last accepted index + 1) mod NUM_CH, pointer updated only on acceptance.
REQ-028 SHALL, with ARB_ROUND_ROBIN_EN undefined, use fixed priority, lowest index highest, no priority state register.

Verification
REQ-029 SHALL cover: ch_req=2'b11, m_addr_ok=1, fixed priority -> ch_addr_ok=2'b01 every cycle; round-robin build -> alternates 01,10,01.
REQ-030 SHALL cover: ch1 requests with m_addr_ok=0 for 3 cycles, ch0 raises in cycle 2 -> m_addr stays ch1 address, ch_addr_ok=2'b10 on cycle 4 acceptance.
REQ-031 SHALL cover: DEPTH=4, 4 acceptances with no m_data_ok -> m_req=0 on 5th cycle; one m_data_ok -> m_req=1 the following cycle.
REQ-032 SHALL cover: accept ch0, ch1, ch0, then 3 m_data_ok with m_rdata 0x11,0x22,0x33 -> ch_data_ok 01,10,01 with ch_rdata 0x11,0x22,0x33.
REQ-033 SHALL cover: m_data_ok with empty FIFO -> ch_data_ok=0; resetn low with 2 outstanding -> count=0, subsequent m_data_ok ignored.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// Multi-channel SRAM-like request arbiter with an in-order response ID FIFO.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin priority (default is fixed priority, lowest index wins).
module sram_req_arbiter #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_wr,
    input  logic [2*NUM_CH-1:0]      ch_size,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [DATA_W*NUM_CH-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_addr_ok,
    output logic [NUM_CH-1:0]        ch_data_ok,
    output logic [DATA_W-1:0]        ch_rdata,
    output logic                     m_req,
    output logic                     m_wr,
    output logic [1:0]               m_size,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [DATA_W-1:0]        m_wdata,
    input  logic                     m_addr_ok,
    input  logic                     m_data_ok,
    input  logic [DATA_W-1:0]        m_rdata
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             lock_q, lock_d;
    logic [SEL_W-1:0] lock_sel_q, lock_sel_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEL_W-1:0] id_q [DEPTH];
    logic [SEL_W-1:0] id_d [DEPTH];

    logic [SEL_W-1:0] arb_sel;
    logic [SEL_W-1:0] sel;
    logic             full;
    logic             lock_void;
    logic             push;
    logic             pop;

`ifdef ARB_ROUND_ROBIN_EN
    logic [SEL_W-1:0] rr_q, rr_d;

    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return SEL_W'(s);
    endfunction

    // rr_q holds the index with highest priority; scan so that rr_q wins last.
    always_comb begin
        arb_sel = rr_q;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_req[wrap_add(rr_q, k)]) begin
                arb_sel = wrap_add(rr_q, k);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (push) begin
            rr_d = wrap_add(sel, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    always_comb begin
        arb_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req[i]) begin
                arb_sel = SEL_W'(i);
            end
        end
    end
`endif

    // A stalled request keeps its grant until accepted, so the downstream sees a stable request.
    assign sel       = lock_q ? lock_sel_q : arb_sel;
    assign lock_void = lock_q && !ch_req[lock_sel_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign m_req     = resetn && ch_req[sel] && !full && !lock_void;
    assign push      = m_req && m_addr_ok;
    assign pop       = resetn && m_data_ok && (count_q != '0);
    assign ch_rdata  = m_rdata;

    always_comb begin
        m_wr    = 1'b0;
        m_size  = 2'b00;
        m_addr  = '0;
        m_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel == SEL_W'(i)) begin
                m_wr    = ch_wr[i];
                m_size  = ch_size[2*i +: 2];
                m_addr  = ch_addr[ADDR_W*i +: ADDR_W];
                m_wdata = ch_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr_ok[i] = push && (sel == SEL_W'(i));
            ch_data_ok[i] = pop && (id_q[rd_ptr_q] == SEL_W'(i));
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (lock_void || push) begin
            lock_d = 1'b0;
        end else if (m_req) begin
            lock_d     = 1'b1;
            lock_sel_d = sel;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        id_d     = id_q;
        if (push) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d       = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock_q     <= 1'b0;
            lock_sel_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ID storage needs no reset: entries are only read while count_q says they are valid.
    always_ff @(posedge clk) begin
        id_q <= id_d;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter: a channel/queue-level model predicts each cycle's handshakes.
module tb_sram_req_arbiter;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DEP = 4;

    logic                clk = 1'b0;
    logic                resetn;
    logic [NCH-1:0]      ch_req, ch_wr;
    logic [2*NCH-1:0]    ch_size;
    logic [AW*NCH-1:0]   ch_addr;
    logic [DW*NCH-1:0]   ch_wdata;
    logic [NCH-1:0]      ch_addr_ok, ch_data_ok;
    logic [DW-1:0]       ch_rdata;
    logic                m_req, m_wr;
    logic [1:0]          m_size;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_wdata;
    logic                m_addr_ok, m_data_ok;
    logic [DW-1:0]       m_rdata;

    sram_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEP)) dut (
        .clk(clk), .resetn(resetn),
        .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr), .ch_wdata(ch_wdata),
        .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit             req;
        bit             wr;
        logic [1:0]     size;
        logic [AW-1:0]  addr;
        logic [DW-1:0]  wdata;
        logic [NCH-1:0] acc;
        bit             rsp;
    } cyc_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
    } rsp_t;

    cyc_t cyc_q[$];
    rsp_t rsp_q[$];

    // Model state: pending master requests, outstanding accepted channels, held grant.
    bit            pend_v[NCH];
    bit            pend_wr[NCH];
    logic [1:0]    pend_size[NCH];
    logic [AW-1:0] pend_addr[NCH];
    logic [DW-1:0] pend_wdata[NCH];
    int            outq[$];
    int            hold_ch = -1;
    int            last_acc = NCH - 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic bit any_pend();
        for (int i = 0; i < NCH; i++) if (pend_v[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int pick();
        if (hold_ch >= 0) return hold_ch;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NCH; k++) if (pend_v[(last_acc + 1 + k) % NCH]) return (last_acc + 1 + k) % NCH;
`else
        for (int i = 0; i < NCH; i++) if (pend_v[i]) return i;
`endif
        return -1;
    endfunction

    task automatic raise(input int ch);
        if (!pend_v[ch]) begin
            pend_v[ch]     = 1'b1;
            pend_wr[ch]    = 1'($urandom_range(0, 1));
            pend_size[ch]  = 2'($urandom_range(0, 2));
            pend_addr[ch]  = $urandom;
            pend_wdata[ch] = $urandom;
        end
    endtask

    task automatic step(input bit rstn, input bit maok, input bit mdok, input logic [DW-1:0] rdata);
        cyc_t e;
        rsp_t r;
        int   g;
        int   size0;
        @(posedge clk);
        #1;
        resetn    = rstn;
        m_addr_ok = maok;
        m_data_ok = mdok;
        m_rdata   = rdata;
        for (int i = 0; i < NCH; i++) begin
            ch_req[i]             = rstn ? pend_v[i] : 1'($urandom_range(0, 1));
            ch_wr[i]              = pend_wr[i];
            ch_size[2*i +: 2]     = pend_size[i];
            ch_addr[AW*i +: AW]   = pend_addr[i];
            ch_wdata[DW*i +: DW]  = pend_wdata[i];
        end
        e = '{default: 0};
        if (!rstn) begin
            hold_ch  = -1;
            last_acc = NCH - 1;
            outq.delete();
            for (int i = 0; i < NCH; i++) pend_v[i] = 1'b0;
        end else begin
            size0 = outq.size();
            g = pick();
            if (g >= 0 && size0 < DEP) begin
                e.req   = 1'b1;
                e.wr    = pend_wr[g];
                e.size  = pend_size[g];
                e.addr  = pend_addr[g];
                e.wdata = pend_wdata[g];
                if (maok) e.acc = NCH'(1) << g;
            end
            hold_ch = (e.req && !maok) ? g : -1;
            if (mdok && size0 > 0) begin
                e.rsp  = 1'b1;
                r.ch   = outq.pop_front();
                r.data = rdata;
                rsp_q.push_back(r);
            end
            if (e.acc != '0) begin
                outq.push_back(g);
                pend_v[g] = 1'b0;
                last_acc  = g;
            end
        end
        cyc_q.push_back(e);
    endtask

    task automatic settle();
        for (int k = 0; k < 40; k++) begin
            if (!any_pend() && outq.size() == 0) break;
            step(1'b1, 1'b1, 1'b1, $urandom);
        end
    endtask

    cyc_t mon_e;
    rsp_t mon_r;

    initial begin
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                mon_e = cyc_q.pop_front();
                chk("m_req", 64'(m_req), 64'(mon_e.req));
                if (mon_e.req) begin
                    chk("m_addr", 64'(m_addr), 64'(mon_e.addr));
                    chk("m_wr", 64'(m_wr), 64'(mon_e.wr));
                    chk("m_size", 64'(m_size), 64'(mon_e.size));
                    chk("m_wdata", 64'(m_wdata), 64'(mon_e.wdata));
                end
                chk("ch_addr_ok", 64'(ch_addr_ok), 64'(mon_e.acc));
                chk("rsp_present", 64'(|ch_data_ok), 64'(mon_e.rsp));
                if (ch_data_ok != '0) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(ch_data_ok), 64'(0));
                    end else begin
                        mon_r = rsp_q.pop_front();
                        chk("ch_data_ok", 64'(ch_data_ok), 64'(1) << mon_r.ch);
                        chk("ch_rdata", 64'(ch_rdata), 64'(mon_r.data));
                    end
                end
            end
        end
    end

    initial begin
        resetn = 1'b0; ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wdata = '0;
        m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            pend_v[i] = 1'b0; pend_wr[i] = 1'b0; pend_size[i] = '0; pend_addr[i] = '0; pend_wdata[i] = '0;
        end

        // Reset with active-looking inputs: all handshake outputs must stay low.
        repeat (3) step(1'b0, 1'b1, 1'b1, $urandom);

        // Both channels requesting with immediate acceptance.
        for (int c = 0; c < 6; c++) begin
            raise(0); raise(1);
            step(1'b1, 1'b1, 1'b1, $urandom);
        end
        settle();

        // ch1 stalls three cycles; ch0 arriving meanwhile must not steal the grant.
        raise(1);
        step(1'b1, 1'b0, 1'b0, '0);
        raise(0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        settle();

        // Fill the ID FIFO, then show a same-cycle pop does not unblock.
        for (int c = 0; c < DEP; c++) begin
            raise(0);
            step(1'b1, 1'b1, 1'b0, '0);
        end
        raise(0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
        step(1'b1, 1'b1, 1'b0, '0);
        settle();

        // In-order responses across channels.
        raise(0); step(1'b1, 1'b1, 1'b0, '0);
        raise(1); step(1'b1, 1'b1, 1'b0, '0);
        raise(0); step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h11);
        step(1'b1, 1'b0, 1'b1, 32'h22);
        step(1'b1, 1'b0, 1'b1, 32'h33);

        // Response with empty FIFO; reset discards outstanding IDs.
        step(1'b1, 1'b0, 1'b1, 32'hDEAD);
        raise(0); step(1'b1, 1'b1, 1'b0, '0);
        raise(1); step(1'b1, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b1, $urandom);
        step(1'b1, 1'b0, 1'b1, 32'hBEEF);
        step(1'b1, 1'b0, 1'b1, 32'hCAFE);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NCH; i++) if ($urandom_range(0, 1) == 1) raise(i);
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 1) == 1), $urandom);
        end
        settle();

        repeat (2) @(posedge clk);
        chk("cyc_q_drained", 64'(cyc_q.size()), 64'(0));
        chk("rsp_q_drained", 64'(rsp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
